// File: rtl/display_pkg.sv
// Shared types and the hex-to-segment table for the display scan controller.
package display_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StBlank = 2'd1,
    StShow  = 2'd2
  } estado_e;

  localparam logic [6:0] SEG_APAGADO = 7'h7F;

  // gfedcba, active-low
  function automatic logic [6:0] hex_a_seg(input logic [3:0] nibble);
    logic [6:0] seg;
    unique case (nibble)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h18;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = SEG_APAGADO;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational hex nibble to active-low gfedcba segment decoder.
module seg7_decoder
  import display_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = hex_a_seg(nibble_i);

endmodule

// File: rtl/display_scan.sv
// Time-multiplexed 7-segment scan controller with blanking gap between digits.
// Optional leading-zero suppression when SUPRIMIR_CEROS_EN is defined.
module display_scan
  import display_pkg::*;
#(
  parameter int unsigned N_DIG       = 4,
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned BLANK_CYC   = 500
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 habilita_i,
  input  logic                 carga_i,
  input  logic [4*N_DIG-1:0]   dato_i,
  input  logic [N_DIG-1:0]     punto_i,
  output logic [6:0]           segmentos_o,
  output logic                 punto_o,
  output logic [N_DIG-1:0]     anodo_o
);

  localparam int unsigned MaxCyc = (REFRESH_DIV > BLANK_CYC) ? REFRESH_DIV : BLANK_CYC;
  localparam int unsigned CntW   = $clog2(MaxCyc + 1);
  localparam int unsigned IdxW   = (N_DIG > 1) ? $clog2(N_DIG) : 1;

  estado_e                  state_q, state_d;
  logic [CntW-1:0]          cnt_q, cnt_d;
  logic [IdxW-1:0]          idx_q, idx_d;
  logic [N_DIG-1:0][3:0]    dato_q;
  logic [N_DIG-1:0]         punto_sh_q;
  logic [6:0]               seg_q, seg_d;
  logic                     pt_q, pt_d;
  logic [N_DIG-1:0]         an_q, an_d;
  logic [6:0]               dec_seg;
  logic [6:0]               seg_show;

  seg7_decoder u_dec (
    .nibble_i (dato_q[idx_q]),
    .seg_o    (dec_seg)
  );

`ifdef SUPRIMIR_CEROS_EN
  logic suprime;

  // Blank a non-rightmost digit whose nibble and every higher nibble are zero.
  always_comb begin
    suprime = (idx_q != '0);
    for (int j = 0; j < N_DIG; j++) begin
      if (IdxW'(j) >= idx_q && dato_q[j] != 4'h0) suprime = 1'b0;
    end
  end

  assign seg_show = suprime ? SEG_APAGADO : dec_seg;
`else
  assign seg_show = dec_seg;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    seg_d   = seg_q;
    pt_d    = pt_q;
    an_d    = an_q;
    if (!habilita_i) begin
      state_d = StIdle;
      cnt_d   = '0;
      idx_d   = '0;
      seg_d   = SEG_APAGADO;
      pt_d    = 1'b1;
      an_d    = '1;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StBlank;
          cnt_d   = '0;
          idx_d   = '0;
          seg_d   = SEG_APAGADO;
          pt_d    = 1'b1;
          an_d    = '1;
        end
        StBlank: begin
          seg_d = SEG_APAGADO;
          pt_d  = 1'b1;
          an_d  = '1;
          if (cnt_q == CntW'(BLANK_CYC - 1)) begin
            // Shadow is sampled here and held for the whole digit.
            state_d     = StShow;
            cnt_d       = '0;
            seg_d       = seg_show;
            pt_d        = ~punto_sh_q[idx_q];
            an_d[idx_q] = 1'b0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StShow: begin
          if (cnt_q == CntW'(REFRESH_DIV - 1)) begin
            state_d = StBlank;
            cnt_d   = '0;
            idx_d   = (idx_q == IdxW'(N_DIG - 1)) ? '0 : idx_q + 1'b1;
            seg_d   = SEG_APAGADO;
            pt_d    = 1'b1;
            an_d    = '1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
          idx_d   = '0;
          seg_d   = SEG_APAGADO;
          pt_d    = 1'b1;
          an_d    = '1;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      seg_q   <= SEG_APAGADO;
      pt_q    <= 1'b1;
      an_q    <= '1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      pt_q    <= pt_d;
      an_q    <= an_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dato_q     <= '0;
      punto_sh_q <= '0;
    end else if (carga_i) begin
      dato_q     <= dato_i;
      punto_sh_q <= punto_i;
    end
  end

  assign segmentos_o = seg_q;
  assign punto_o     = pt_q;
  assign anodo_o     = an_q;

endmodule

// File: tb/tb_display_scan.sv
// Bench for display_scan: timeline model checked every cycle plus directed literal checks.
module tb_display_scan;

  localparam int N_DIG       = 4;
  localparam int REFRESH_DIV = 4;
  localparam int BLANK_CYC   = 1;
  localparam int SLOT        = REFRESH_DIV + BLANK_CYC;

  logic                 clk;
  logic                 rst;
  logic                 hab;
  logic                 carga;
  logic [4*N_DIG-1:0]   dato;
  logic [N_DIG-1:0]     punto;
  logic [6:0]           seg;
  logic                 pt;
  logic [N_DIG-1:0]     an;

  int compared   = 0;
  int mismatched = 0;

  display_scan #(
    .N_DIG       (N_DIG),
    .REFRESH_DIV (REFRESH_DIV),
    .BLANK_CYC   (BLANK_CYC)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .habilita_i  (hab),
    .carga_i     (carga),
    .dato_i      (dato),
    .punto_i     (punto),
    .segmentos_o (seg),
    .punto_o     (pt),
    .anodo_o     (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] dec_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Model: time since enable decides blank/show slot; digit latched at slot start.
  logic [6:0]         m_seg;
  logic               m_pt;
  logic [N_DIG-1:0]   m_an;
  logic [4*N_DIG-1:0] m_dato;
  logic [N_DIG-1:0]   m_psh;
  bit                 running;
  int                 t;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_seg = 7'h7F; m_pt = 1'b1; m_an = '1;
      m_dato = '0; m_psh = '0; running = 0; t = 0;
    end else begin
      if (!hab) begin
        running = 0;
        m_seg = 7'h7F; m_pt = 1'b1; m_an = '1;
      end else if (!running) begin
        running = 1; t = 0;
        m_seg = 7'h7F; m_pt = 1'b1; m_an = '1;
      end else begin
        int pos, dig;
        logic [3:0] nib;
        t++;
        pos = t % SLOT;
        dig = (t / SLOT) % N_DIG;
        if (pos < BLANK_CYC) begin
          m_seg = 7'h7F; m_pt = 1'b1; m_an = '1;
        end else if (pos == BLANK_CYC) begin
          nib   = m_dato[4*dig +: 4];
          m_seg = dec_tab[nib];
`ifdef SUPRIMIR_CEROS_EN
          if (dig > 0 && (m_dato >> (4 * dig)) == 0) m_seg = 7'h7F;
`endif
          m_pt = ~m_psh[dig];
          m_an = ~(N_DIG'(1) << dig);
        end
      end
      if (carga) begin
        m_dato = dato;
        m_psh  = punto;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("model_seg", 32'(seg), 32'(m_seg));
    check("model_pt",  32'(pt),  32'(m_pt));
    check("model_an",  32'(an),  32'(m_an));
  end

  task automatic step(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic lit(input string name, input logic [N_DIG-1:0] e_an, input logic [6:0] e_seg);
    check({name, "_an"},  32'(an),  32'(e_an));
    check({name, "_seg"}, 32'(seg), 32'(e_seg));
  endtask

`ifdef SUPRIMIR_CEROS_EN
  localparam logic [6:0] LeadZero = 7'h7F;
`else
  localparam logic [6:0] LeadZero = 7'h40;
`endif

  initial begin
    rst = 1'b1; hab = 1'b0; carga = 1'b0; dato = '0; punto = '0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      lit("reset", 4'hF, 7'h7F);
      check("reset_pt", 32'(pt), 32'd1);
    end
    // Scan order
    rst = 1'b0; hab = 1'b1; carga = 1'b1; dato = 16'h12A0;
    step(1); carga = 1'b0; lit("first_blank", 4'hF, 7'h7F);
    step(1); lit("dig0", 4'b1110, 7'h40);
    step(4); lit("gap0", 4'hF, 7'h7F);
    step(1); lit("dig1", 4'b1101, 7'h08);
    step(5); lit("dig2", 4'b1011, 7'h24);
    step(5); lit("dig3", 4'b0111, 7'h79);
    step(5); lit("wrap", 4'b1110, 7'h40);
    // Mid-digit load during digit 1
    step(6); carga = 1'b1; dato = 16'hFFFF;
    step(1); carga = 1'b0;
    step(1); lit("mid_keep", 4'b1101, 7'h08);
    step(2); lit("mid_next", 4'b1011, 7'h0E);
    // Disable during SHOW, then re-enable
    step(1); hab = 1'b0;
    step(1); lit("disabled", 4'hF, 7'h7F);
    step(1); hab = 1'b1; carga = 1'b1; dato = 16'h12A0; punto = 4'b0100;
    step(1); carga = 1'b0; lit("reen_blank", 4'hF, 7'h7F);
    step(1); lit("reen_dig0", 4'b1110, 7'h40); check("pt_d0", 32'(pt), 32'd1);
    step(5); check("pt_d1", 32'(pt), 32'd1);
    step(5); lit("pt_dig2", 4'b1011, 7'h24); check("pt_d2", 32'(pt), 32'd0);
    // Leading zeros
    step(3); carga = 1'b1; dato = 16'h0050; punto = '0;
    step(1); carga = 1'b0;
    step(1); lit("lz_dig3", 4'b0111, LeadZero);
    step(5); lit("lz_dig0", 4'b1110, 7'h40);
    step(5); lit("lz_dig1", 4'b1101, 7'h12);
    step(5); lit("lz_dig2", 4'b1011, LeadZero);
    // Async reset mid-scan
    step(1); #2 rst = 1'b1;
    step(1); lit("async_rst", 4'hF, 7'h7F); check("async_rst_pt", 32'(pt), 32'd1);
    step(1); rst = 1'b0;
    step(2); lit("post_rst", 4'b1110, 7'h40);
    step(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
